// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: synchronizes and debounces two raw push-buttons, then emits single-cycle
// S/R pulses that are never high together, plus a shadow of the downstream SR flip-flop Q.
module sr_cmd_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          PRIORITY_RESET  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic S,
    output logic R,
    output logic conflict,
    output logic q_shadow
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 carries the set button, channel 1 the reset button.
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  level_q, level_d;
    logic [1:0]                  level_prev_q, level_prev_d;
    logic [1:0]                  btn;
    logic [1:0]                  req;
    logic                        s_q, s_d;
    logic                        r_q, r_d;
    logic                        conflict_q, conflict_d;
    logic                        q_shadow_q, q_shadow_d;

    assign btn = {rst_btn, set_btn};

    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            sync_d[ch]       = {sync_q[ch][SYNC_STAGES-2:0], btn[ch]};
            cnt_d[ch]        = '0;
            level_d[ch]      = level_q[ch];
            level_prev_d[ch] = level_q[ch];
            // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing edge.
            if (sync_q[ch][SYNC_STAGES-1] != level_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    level_d[ch] = sync_q[ch][SYNC_STAGES-1];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
            req[ch] = level_q[ch] & ~level_prev_q[ch];
        end

        s_d        = req[0] & ~req[1];
        r_d        = req[1] & (~req[0] | PRIORITY_RESET);
        conflict_d = req[0] & req[1];

        q_shadow_d = q_shadow_q;
        if (s_q) begin
            q_shadow_d = 1'b1;
        end else if (r_q) begin
            q_shadow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            conflict_q   <= 1'b0;
            q_shadow_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            s_q          <= s_d;
            r_q          <= r_d;
            conflict_q   <= conflict_d;
            q_shadow_q   <= q_shadow_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;
    assign q_shadow = q_shadow_q;
endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: two instances (reset-priority and drop-both) driven by shared buttons,
// checked every cycle against a history-window model plus hand-computed pulse timings.
module tb_sr_cmd_gen;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int NE = 512;

    logic clk = 1'b0;
    logic rst_n, set_btn, rst_btn;
    logic s_a, r_a, c_a, q_a;
    logic s_b, r_b, c_b, q_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .PRIORITY_RESET(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
        .S(s_a), .R(r_a), .conflict(c_a), .q_shadow(q_a)
    );

    sr_cmd_gen #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .PRIORITY_RESET(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
        .S(s_b), .R(r_b), .conflict(c_b), .q_shadow(q_b)
    );

    // Per-edge history: inputs seen at edge n and the outputs expected right after edge n.
    bit raw_s[NE], raw_r[NE], rst_at[NE];
    bit lvl_s[NE], lvl_r[NE];
    bit ms_a[NE], mr_a[NE], mq_a[NE];
    bit ms_b[NE], mr_b[NE], mq_b[NE];
    bit mc[NE];
    int edge_n = -1;

    // Synced value after edge k: the raw sample from SS-1 edges earlier, unless a reset intervened.
    function automatic bit syncv(input bit ch, input int k);
        if (k - SS + 1 < 0) return 1'b0;
        for (int j = k - SS + 1; j <= k; j++) begin
            if (rst_at[j]) return 1'b0;
        end
        return ch ? raw_r[k-SS+1] : raw_s[k-SS+1];
    endfunction

    // Level flips only when the DC synced values preceding this edge all disagree with it.
    function automatic bit next_lvl(input bit ch, input int n, input bit prev);
        for (int j = n - DC; j < n; j++) begin
            if (j < 0) return prev;
            if (syncv(ch, j) == prev) return prev;
        end
        return !prev;
    endfunction

    initial begin
        int n;
        bit sreq, rreq;
        forever begin
            @(posedge clk);
            edge_n++;
            n = edge_n;
            if (n < NE) begin
                raw_s[n]  = set_btn;
                raw_r[n]  = rst_btn;
                rst_at[n] = !rst_n;
                if (!rst_n || n < 2) begin
                    lvl_s[n] = 1'b0; lvl_r[n] = 1'b0;
                    ms_a[n] = 1'b0; mr_a[n] = 1'b0; mq_a[n] = 1'b0;
                    ms_b[n] = 1'b0; mr_b[n] = 1'b0; mq_b[n] = 1'b0;
                    mc[n] = 1'b0;
                end else begin
                    lvl_s[n] = next_lvl(1'b0, n, lvl_s[n-1]);
                    lvl_r[n] = next_lvl(1'b1, n, lvl_r[n-1]);
                    sreq = lvl_s[n-1] && !lvl_s[n-2];
                    rreq = lvl_r[n-1] && !lvl_r[n-2];
                    mc[n]   = sreq && rreq;
                    ms_a[n] = sreq && !rreq;
                    mr_a[n] = rreq;
                    ms_b[n] = sreq && !rreq;
                    mr_b[n] = rreq && !sreq;
                    mq_a[n] = ms_a[n-1] ? 1'b1 : (mr_a[n-1] ? 1'b0 : mq_a[n-1]);
                    mq_b[n] = ms_b[n-1] ? 1'b1 : (mr_b[n-1] ? 1'b0 : mq_b[n-1]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    int s_cnt_a = 0, s_last_a = -1, r_cnt_a = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (edge_n >= 0 && edge_n < NE) begin
                check("S_a", s_a, ms_a[edge_n]);
                check("R_a", r_a, mr_a[edge_n]);
                check("conflict_a", c_a, mc[edge_n]);
                check("q_shadow_a", q_a, mq_a[edge_n]);
                check("S_b", s_b, ms_b[edge_n]);
                check("R_b", r_b, mr_b[edge_n]);
                check("conflict_b", c_b, mc[edge_n]);
                check("q_shadow_b", q_b, mq_b[edge_n]);
                check("S_and_R_a", s_a & r_a, 0);
                check("S_and_R_b", s_b & r_b, 0);
                if (s_a === 1'b1) begin
                    s_cnt_a++;
                    s_last_a = edge_n;
                end
                if (r_a === 1'b1) r_cnt_a++;
            end
        end
    end

    // Returns at the negedge after edge e-1, so inputs set now are sampled at edge e.
    task automatic goto_edge(input int e);
        for (int i = 0; i < 1000 && edge_n < e - 1; i++) @(negedge clk);
        if (edge_n < e - 1) check("goto_edge_timeout", edge_n, e - 1);
    endtask

    task automatic settle_check_point(input int e);
        goto_edge(e);
        #1;
    endtask

    initial begin
        int base_s, base_r;
        rst_n = 1'b0; set_btn = 1'b0; rst_btn = 1'b0;
        settle_check_point(2);
        check("reset_S", s_a, 0);
        check("reset_q", q_a, 0);
        goto_edge(4); rst_n = 1'b1;

        // Clean press held 20 cycles: one S after edge 16, q_shadow rises after edge 17.
        base_s = s_cnt_a; base_r = r_cnt_a;
        goto_edge(10); set_btn = 1'b1;
        settle_check_point(17);
        check("clean_S_at16", s_a, 1);
        check("clean_q_at16", q_a, 0);
        settle_check_point(18);
        check("clean_S_at17", s_a, 0);
        check("clean_q_at17", q_a, 1);
        goto_edge(30); set_btn = 1'b0;
        settle_check_point(38);
        check("clean_S_count", s_cnt_a - base_s, 1);
        check("clean_S_edge", s_last_a, 16);
        check("clean_R_count", r_cnt_a - base_r, 0);

        // Bounce on reset button never reaches the debounce threshold.
        base_r = r_cnt_a;
        for (int e = 40; e < 46; e++) begin
            goto_edge(e); rst_btn = (e % 2 == 0);
        end
        goto_edge(46); rst_btn = 1'b0;
        settle_check_point(56);
        check("bounce_R_count", r_cnt_a - base_r, 0);
        check("bounce_q_a", q_a, 1);
        check("bounce_q_b", q_b, 1);

        // Two short set glitches, then a settled press from edge 70.
        base_s = s_cnt_a;
        goto_edge(60); set_btn = 1'b1;
        goto_edge(61); set_btn = 1'b0;
        goto_edge(62); set_btn = 1'b1;
        goto_edge(63); set_btn = 1'b0;
        goto_edge(70); set_btn = 1'b1;
        goto_edge(90); set_btn = 1'b0;
        settle_check_point(98);
        check("settle_S_count", s_cnt_a - base_s, 1);
        check("settle_S_edge", s_last_a, 76);

        // Simultaneous press at edge 100.
        goto_edge(100); set_btn = 1'b1; rst_btn = 1'b1;
        settle_check_point(107);
        check("simul_R_a", r_a, 1);
        check("simul_S_a", s_a, 0);
        check("simul_conflict_a", c_a, 1);
        check("simul_R_b", r_b, 0);
        check("simul_S_b", s_b, 0);
        check("simul_conflict_b", c_b, 1);
        settle_check_point(108);
        check("simul_q_a", q_a, 0);
        check("simul_q_b", q_b, 1);
        goto_edge(115); set_btn = 1'b0; rst_btn = 1'b0;

        // Back-to-back: set one edge ahead of reset.
        goto_edge(130); set_btn = 1'b1;
        goto_edge(131); rst_btn = 1'b1;
        settle_check_point(137);
        check("b2b_S_at136", s_a, 1);
        check("b2b_R_at136", r_a, 0);
        settle_check_point(138);
        check("b2b_S_at137", s_a, 0);
        check("b2b_R_at137", r_a, 1);
        check("b2b_q_at137", q_a, 1);
        check("b2b_R_b_at137", r_b, 1);
        settle_check_point(139);
        check("b2b_q_at138", q_a, 0);
        check("b2b_q_b_at138", q_b, 0);
        goto_edge(145); set_btn = 1'b0; rst_btn = 1'b0;

        // Reset mid-debounce with the button still held.
        base_s = s_cnt_a;
        goto_edge(160); set_btn = 1'b1;
        goto_edge(163); rst_n = 1'b0;
        settle_check_point(164);
        check("midrst_S", s_a, 0);
        check("midrst_q", q_a, 0);
        goto_edge(165); rst_n = 1'b1;
        settle_check_point(185);
        check("midrst_S_count", s_cnt_a - base_s, 1);
        check("midrst_S_edge", s_last_a, 171);
        set_btn = 1'b0;

        settle_check_point(200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
